// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage: fetches one word per instruction over
// a req/ack handshake, holds it for the controller, and applies relative or absolute redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_AW      = 8,
    parameter logic [31:0] INSTR_IDLE   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               retire,
    input  logic               next_abs,
    input  logic [31:0]        next,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    output logic [31:0]        instruction,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        ctr_out,
    output logic               fault
);

    // state  | meaning
    // FETCH  | raise the memory request for the word at pc
    // WAIT   | request outstanding, waiting for imem_ack
    // EXEC   | instruction valid, waiting for the controller to retire it
    // HALT   | misaligned redirect seen; only reset leaves
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        fault_q, fault_d;

    logic [31:0] new_pc;
    logic        misaligned;

    always_comb begin
        new_pc     = next_abs ? {next[31:1], 1'b0} : pc_q + next;
        misaligned = (new_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            instr_q <= INSTR_IDLE;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  if (imem_ack) state_d = S_EXEC;
            S_EXEC:  if (retire) state_d = misaligned ? S_HALT : S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Acks outside WAIT and retires outside EXEC fall through to the hold defaults.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: req_d = 1'b1;
            S_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    instr_d = INSTR_IDLE;
                    valid_d = 1'b0;
                    if (misaligned) fault_d = 1'b1;
                    else            pc_d    = new_pc;
                end
            end
            S_HALT: begin
                req_d   = 1'b0;
                instr_d = INSTR_IDLE;
                valid_d = 1'b0;
            end
            default: req_d = 1'b0;
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign ctr_out     = pc_q + 32'd4;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC reference model queues expected fetches,
// and a monitor compares every fetch address and delivered instruction.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        retire;
    logic        next_abs;
    logic [31:0] next;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] ctr_out;
    logic        fault;

    fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .IMEM_AW(8),
        .INSTR_IDLE(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .retire(retire),
        .next_abs(next_abs),
        .next(next),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack(imem_ack),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc(pc),
        .ctr_out(ctr_out),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 0;
    bit          inject_ack = 1'b0;
    logic [31:0] ref_pc;
    logic        ref_fault;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: acks mem_lat cycles after a request is first seen.
    initial begin
        int lat_cnt;
        bit seen;
        lat_cnt = 0;
        seen = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (inject_ack) begin
                imem_ack = 1'b1;
            end else if (imem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat_cnt = mem_lat;
                end
                if (lat_cnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem[imem_addr];
                    seen = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Monitor: checks each new request address and each delivered instruction.
    initial begin
        logic prev_valid;
        logic prev_req;
        exp_t e;
        prev_valid = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr %h with no fetch expected", imem_addr);
                end else begin
                    check("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_q[0].pc[9:2]});
                end
            end
            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: instruction %h with no fetch expected", instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("instruction", instruction, e.instr);
                    check("pc_at_valid", pc, e.pc);
                    check("ctr_out", ctr_out, e.pc + 32'd4);
                end
            end
            prev_valid = instr_valid;
            prev_req = imem_req;
        end
    end

    task automatic wait_valid(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (instr_valid) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: instr_valid 0 after %0d cycles, expected 1", budget);
        end
    endtask

    task automatic do_retire(input logic abs, input logic [31:0] nxt);
        logic [31:0] np;
        wait_valid(60);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #2;
        retire = 1'b1;
        next_abs = abs;
        next = nxt;
        np = abs ? (nxt & ~32'd1) : ref_pc + nxt;
        if (np[1:0] != 2'b00) begin
            ref_fault = 1'b1;
        end else begin
            ref_pc = np;
            exp_q.push_back('{pc: np, instr: mem[np[9:2]]});
        end
        @(posedge clk);
        #2;
        retire = 1'b0;
        next = $urandom;
        next_abs = 1'($urandom_range(0, 1));
        check("pc_after_retire", pc, ref_pc);
        check("valid_after_retire", {31'h0, instr_valid}, 32'h0);
        check("fault_after_retire", {31'h0, fault}, {31'h0, ref_fault});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          got;
        rst = 1'b0;
        retire = 1'b0;
        next_abs = 1'b0;
        next = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        ref_pc = 32'h0;
        ref_fault = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_ctr_out", ctr_out, 32'h4);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_addr", {24'h0, imem_addr}, 32'h0);
        exp_q.push_back('{pc: 32'h0, instr: mem[0]});
        rst = 1'b1;

        // Directed redirects, including the 32-bit wrap and absolute bit0 clear.
        do_retire(1'b0, 32'h4);
        do_retire(1'b0, 32'hFFFF_FFF8);
        do_retire(1'b0, 32'h4);
        do_retire(1'b1, 32'h21);

        // Stalled memory: request and address held, retire in WAIT ignored.
        mem_lat = 5;
        do_retire(1'b0, 32'h4);
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (imem_req) got = 1'b1;
        end
        check("stall_req_seen", {31'h0, imem_req}, 32'h1);
        @(posedge clk);
        #2;
        retire = 1'b1;
        next = 32'h40;
        @(posedge clk);
        #2;
        retire = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            @(negedge clk);
            if (!instr_valid) begin
                check("stall_req", {31'h0, imem_req}, 32'h1);
                check("stall_addr", {24'h0, imem_addr}, {24'h0, ref_pc[9:2]});
                check("stall_instruction", instruction, 32'h0);
                check("stall_pc", pc, ref_pc);
            end
        end

        // Randomised redirects with aligned targets and random memory latency.
        for (int k = 0; k < 30; k++) begin
            mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom;
                a[1] = 1'b0;
                do_retire(1'b1, a);
            end else begin
                d = 32'($urandom_range(0, 64)) - 32'd32;
                do_retire(1'b0, d << 2);
            end
        end

        // Misaligned redirect: sticky fault and halt.
        mem_lat = 0;
        do_retire(1'b1, 32'h8);
        do_retire(1'b0, 32'h2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_req", {31'h0, imem_req}, 32'h0);
            check("halt_pc", pc, 32'h8);
            check("halt_fault", {31'h0, fault}, 32'h1);
            check("halt_instruction", instruction, 32'h0);
        end
        @(posedge clk);
        #2;
        retire = 1'b1;
        next_abs = 1'b0;
        next = 32'h4;
        @(posedge clk);
        #2;
        retire = 1'b0;
        @(negedge clk);
        check("halt_retire_pc", pc, 32'h8);
        check("halt_retire_fault", {31'h0, fault}, 32'h1);

        // Reset clears the fault; then reset mid-WAIT with a late ack.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("fault_cleared", {31'h0, fault}, 32'h0);
        check("halt_rst_pc", pc, 32'h0);
        ref_pc = 32'h0;
        ref_fault = 1'b0;
        exp_q.delete();
        exp_q.push_back('{pc: 32'h0, instr: mem[0]});
        mem_lat = 100;
        @(posedge clk);
        #3;
        rst = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (imem_req) got = 1'b1;
        end
        check("wait_req_seen", {31'h0, imem_req}, 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        inject_ack = 1'b1;
        @(posedge clk);
        #3;
        inject_ack = 1'b0;
        @(posedge clk);
        #3;
        check("wait_rst_pc", pc, 32'h0);
        check("wait_rst_req", {31'h0, imem_req}, 32'h0);
        check("wait_rst_valid", {31'h0, instr_valid}, 32'h0);
        check("wait_rst_instruction", instruction, 32'h0);
        exp_q.delete();
        exp_q.push_back('{pc: 32'h0, instr: mem[0]});
        mem_lat = 1;
        rst = 1'b1;
        wait_valid(20);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
